lfsr_param: RTL and testbench

Parametrised pseudo-random sequence generator. Supports widths of 8, 16, 32 and 64 bits, with Fibonacci or Galois feedback selectable at run time. It adds seed load, step enable, all-zero lockup recovery and run-time period measurement. It is the generation source for the game's seed path, and WIDTH=64 replaces a chained 8-bit build.

---
 rtl/lfsr_param.sv | 117 +++++++++++
 tb/tb_lfsr_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_param.sv
// Parametrised LFSR (8/16/32/64 bits) with run-time Fibonacci/Galois feedback,
// seed load, all-zero lockup recovery and period measurement against the start value.
module lfsr_param #(
  parameter int unsigned           WIDTH      = 8,
  parameter logic [WIDTH-1:0]      RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             clr_err,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup_err
);

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $error("lfsr_param: WIDTH must be 8, 16, 32 or 64");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_param: RESET_SEED must be nonzero");
  end

  // Fibonacci mask has bit t-1 set per tap; Galois POLY has bit t per tap t<WIDTH plus bit 0.
  localparam logic [63:0] FIB_TAPS64 =
    (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
    (WIDTH == 16) ? 64'h0000_0000_0000_D008 :
    (WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                    64'hD800_0000_0000_0000;
  localparam logic [63:0] POLY64 =
    (WIDTH == 8)  ? 64'h0000_0000_0000_0071 :
    (WIDTH == 16) ? 64'h0000_0000_0000_A011 :
    (WIDTH == 32) ? 64'h0000_0000_0040_0007 :
                    64'hB000_0000_0000_0001;

  localparam logic [WIDTH-1:0] FIB_MASK = FIB_TAPS64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] POLY     = POLY64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] plen_q, plen_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] next_raw;
  logic [WIDTH-1:0] seed_fix;
  logic             fib_fb;
  logic             err_set;

  always_comb begin
    fib_fb   = ^(state_q & FIB_MASK);
    next_raw = mode ? ({state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? POLY : '0))
                    : {state_q[WIDTH-2:0], fib_fb};
    seed_fix = (seed == '0) ? ONE : seed;

    state_d  = state_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    plen_d   = plen_q;
    done_d   = 1'b0;
    err_set  = 1'b0;

    if (load) begin
      state_d = seed_fix;
      start_d = seed_fix;
      cnt_d   = '0;
      err_set = (seed == '0);
    end else if (en) begin
      if (next_raw == '0) begin
        state_d = ONE;
        err_set = 1'b1;
      end else begin
        state_d = next_raw;
      end
      cnt_d = cnt_q + ONE;
      // Return to the start value: report the new count and restart counting.
      if (state_d == start_q) begin
        done_d = 1'b1;
        plen_d = cnt_q + ONE;
        cnt_d  = '0;
      end
    end

    err_d = err_set ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_SEED;
      start_q <= RESET_SEED;
      cnt_q   <= '0;
      plen_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign state       = state_q;
  assign step_cnt    = cnt_q;
  assign period_done = done_q;
  assign period_len  = plen_q;
  assign lockup_err  = err_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Scoreboard bench for lfsr_param: directed 8-bit vectors with hand-computed
// expectations, plus randomised 16/64-bit runs checked against a tap-list model.
module tb_lfsr_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit DUT
  logic       en8, mode8, load8, clr8;
  logic [7:0] seed8;
  logic [7:0] st8, cnt8, plen8;
  logic       pd8, err8;

  // 16/64-bit DUTs share random controls
  logic        enr, moder, loadr, clrr;
  logic [63:0] seedr;
  logic [15:0] st16, cnt16, plen16;
  logic        pd16, err16;
  logic [63:0] st64, cnt64, plen64;
  logic        pd64, err64;

  lfsr_param #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .en(en8), .mode(mode8), .load(load8), .seed(seed8),
    .clr_err(clr8), .state(st8), .step_cnt(cnt8), .period_done(pd8),
    .period_len(plen8), .lockup_err(err8));

  lfsr_param #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .en(enr), .mode(moder), .load(loadr), .seed(seedr[15:0]),
    .clr_err(clrr), .state(st16), .step_cnt(cnt16), .period_done(pd16),
    .period_len(plen16), .lockup_err(err16));

  lfsr_param #(.WIDTH(64)) u64 (
    .clk(clk), .reset(reset), .en(enr), .mode(moder), .load(loadr), .seed(seedr),
    .clr_err(clrr), .state(st64), .step_cnt(cnt64), .period_done(pd64),
    .period_len(plen64), .lockup_err(err64));

  typedef struct {
    string       name;
    logic [63:0] st, cnt, plen;
    logic        pd, err;
    bit          care_st, care_cnt;
  } exp_t;

  typedef struct {
    logic [63:0] st, start, cnt, plen;
    logic        pd, err;
  } mdl_t;

  exp_t q8[$], q16[$], q64[$];
  exp_t me;
  int unsigned n_vec = 0, n_bad = 0;
  mdl_t m16, m64;

  task automatic check(input exp_t e, input logic [63:0] st, cnt, plen, input logic pd, err);
    bit bad;
    bad = 1'b0;
    n_vec++;
    if (e.care_st && st !== e.st) bad = 1'b1;
    if (e.care_cnt && cnt !== e.cnt) bad = 1'b1;
    if (plen !== e.plen || pd !== e.pd || err !== e.err) bad = 1'b1;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got st=%h cnt=%h pd=%b plen=%h err=%b; want st=%h cnt=%h pd=%b plen=%h err=%b",
               e.name, st, cnt, pd, plen, err, e.st, e.cnt, e.pd, e.plen, e.err);
    end
  endtask

  // Monitor: outputs settle just after each clock edge or an asynchronous reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (q8.size() != 0) begin
        me = q8.pop_front();
        check(me, 64'(st8), 64'(cnt8), 64'(plen8), pd8, err8);
      end
      if (q16.size() != 0) begin
        me = q16.pop_front();
        check(me, 64'(st16), 64'(cnt16), 64'(plen16), pd16, err16);
      end
      if (q64.size() != 0) begin
        me = q64.pop_front();
        check(me, st64, cnt64, plen64, pd64, err64);
      end
    end
  end

  function automatic exp_t mk(string nm, logic [63:0] st, cnt, logic pd, logic [63:0] plen,
                              logic err, bit cs, bit cc);
    exp_t e;
    e.name = nm; e.st = st; e.cnt = cnt; e.pd = pd; e.plen = plen; e.err = err;
    e.care_st = cs; e.care_cnt = cc;
    return e;
  endfunction

  task automatic v8(input string nm, input logic e, m, l, input logic [7:0] sd, input logic c,
                    input logic [63:0] st, cnt, input logic pd, input logic [63:0] plen,
                    input logic err, input bit cs = 1'b1);
    @(negedge clk);
    en8 = e; mode8 = m; load8 = l; seed8 = sd; clr8 = c;
    q8.push_back(mk(nm, st, cnt, pd, plen, err, cs, 1'b1));
  endtask

  function automatic logic [63:0] wmask(int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_next(int unsigned w, logic [63:0] s, logic md);
    int unsigned taps[4];
    logic [63:0] poly, n;
    logic fb;
    case (w)
      8:       taps = '{8, 6, 5, 4};
      16:      taps = '{16, 15, 13, 4};
      32:      taps = '{32, 22, 2, 1};
      default: taps = '{64, 63, 61, 60};
    endcase
    if (!md) begin
      fb = 1'b0;
      for (int unsigned i = 0; i < 4; i++) fb ^= s[taps[i]-1];
      n = ((s << 1) | 64'(fb)) & wmask(w);
    end else begin
      poly = 64'd1;
      for (int unsigned i = 0; i < 4; i++) if (taps[i] < w) poly[taps[i]] = 1'b1;
      n = (s << 1) & wmask(w);
      if (s[w-1]) n ^= poly;
    end
    return n;
  endfunction

  function automatic mdl_t ref_cycle(int unsigned w, mdl_t m, logic e, md, ld,
                                     logic [63:0] sd, logic c);
    mdl_t r;
    logic [63:0] n, s;
    logic set;
    r = m; r.pd = 1'b0; set = 1'b0;
    s = sd & wmask(w);
    if (ld) begin
      r.st = (s == 0) ? 64'd1 : s;
      r.start = r.st;
      r.cnt = 0;
      set = (s == 0);
    end else if (e) begin
      n = ref_next(w, m.st, md);
      if (n == 0) begin n = 64'd1; set = 1'b1; end
      r.st = n;
      r.cnt = (m.cnt + 64'd1) & wmask(w);
      if (n == m.start) begin r.pd = 1'b1; r.plen = r.cnt; r.cnt = 0; end
    end
    if (set) r.err = 1'b1;
    else if (c) r.err = 1'b0;
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    en8 = 0; mode8 = 0; load8 = 0; seed8 = '0; clr8 = 0;
    enr = 0; moder = 0; loadr = 0; clrr = 0; seedr = '0;

    v8("reset_state", 0, 0, 0, 8'h00, 0, 64'h01, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b1;

    // Fibonacci from reset seed 0x01
    v8("fib1", 1, 0, 0, 8'h00, 0, 64'h02, 1, 0, 0, 0);
    v8("fib2", 1, 0, 0, 8'h00, 0, 64'h04, 2, 0, 0, 0);
    v8("fib3", 1, 0, 0, 8'h00, 0, 64'h08, 3, 0, 0, 0);
    v8("fib4", 1, 0, 0, 8'h00, 0, 64'h11, 4, 0, 0, 0);
    v8("fib5", 1, 0, 0, 8'h00, 0, 64'h23, 5, 0, 0, 0);

    // Galois from 0x80
    v8("gal_load",  0, 1, 1, 8'h80, 0, 64'h80, 0, 0, 0, 0);
    v8("gal_step1", 1, 1, 0, 8'h00, 0, 64'h71, 1, 0, 0, 0);
    v8("gal_step2", 1, 1, 0, 8'h00, 0, 64'hE2, 2, 0, 0, 0);
    v8("gal_step3", 1, 1, 0, 8'h00, 0, 64'hB5, 3, 0, 0, 0);
    v8("hold",      0, 1, 0, 8'h00, 0, 64'hB5, 3, 0, 0, 0);

    v8("load_beats_en", 1, 0, 1, 8'h5A, 0, 64'h5A, 0, 0, 0, 0);

    // Zero seed and sticky error
    v8("zero_load",      0, 0, 1, 8'h00, 0, 64'h01, 0, 0, 0, 1);
    v8("err_sticky",     0, 0, 0, 8'h00, 0, 64'h01, 0, 0, 0, 1);
    v8("set_beats_clr",  0, 0, 1, 8'h00, 1, 64'h01, 0, 0, 0, 1);
    v8("clr_err",        0, 0, 0, 8'h00, 1, 64'h01, 0, 0, 0, 0);

    // Two full 255-step periods, Fibonacci then Galois
    v8("period_load", 0, 0, 1, 8'h01, 0, 64'h01, 0, 0, 0, 0);
    for (int k = 1; k <= 255; k++)
      v8((k == 255) ? "fib_period_ret" : "fib_period_mid", 1, 0, 0, 8'h00, 0,
         64'h01, (k == 255) ? 0 : k, (k == 255), (k == 255) ? 255 : 0, 0, (k == 255));
    for (int k = 1; k <= 255; k++)
      v8((k == 255) ? "gal_period_ret" : "gal_period_mid", 1, 1, 0, 8'h00, 0,
         64'h01, (k == 255) ? 0 : k, (k == 255), 255, 0, (k == 255));
    v8("post_pulse",  1, 1, 0, 8'h00, 0, 64'h02, 1, 0, 255, 0);
    v8("zero_load2",  0, 1, 1, 8'h00, 0, 64'h01, 0, 0, 255, 1);
    v8("pre_reset",   1, 1, 0, 8'h00, 0, 64'h02, 1, 0, 255, 1);

    // Asynchronous reset mid-run, en still high
    @(negedge clk);
    q8.push_back(mk("reset_async", 64'h01, 0, 0, 0, 0, 1'b1, 1'b1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; en8 = 0; load8 = 0;
    v8("post_reset_hold", 0, 0, 0, 8'h00, 0, 64'h01, 0, 0, 0, 0);

    // Random 16/64-bit run; both DUTs idle since reset
    m16 = '{st: 64'd1, start: 64'd1, cnt: 0, plen: 0, pd: 1'b0, err: 1'b0};
    m64 = m16;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      enr   = ($urandom_range(0, 3) != 0);
      loadr = ($urandom_range(0, 19) == 0);
      clrr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 24) == 0) moder = ~moder;
      seedr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) seedr = '0;
      m16 = ref_cycle(16, m16, enr, moder, loadr, seedr, clrr);
      m64 = ref_cycle(64, m64, enr, moder, loadr, seedr, clrr);
      q16.push_back(mk("rand16", m16.st, m16.cnt, m16.pd, m16.plen, m16.err, 1'b1, 1'b1));
      q64.push_back(mk("rand64", m64.st, m64.cnt, m64.pd, m64.plen, m64.err, 1'b1, 1'b1));
    end
    @(negedge clk);
    enr = 0; loadr = 0; clrr = 0;

    for (int i = 0; i < 10 && (q8.size() + q16.size() + q64.size()) != 0; i++) @(posedge clk);
    #2;
    if ((q8.size() + q16.size() + q64.size()) != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0",
               q8.size() + q16.size() + q64.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
